cube_root_seq: RTL

//  Sequential integer cube root: the inverse of the a_cube datapath.

---
 rtl/cube_arith_pkg.sv | 25 ++
 rtl/cube_root_mul.sv | 18 +
 rtl/cube_root_seq.sv | 131 +++++++++++++
 3 files changed

// File: rtl/cube_arith_pkg.sv
// Shared types and width helpers for the cube / cube-root arithmetic blocks.
package cube_arith_pkg;

   localparam int ROOT_W_DEF = 8;

   function automatic int in_w(input int root_w);
      return 3 * root_w;
   endfunction

   function automatic int sq_w(input int root_w);
      return 2 * root_w;
   endfunction

   localparam int IN_W_DEF = in_w(ROOT_W_DEF);
   localparam int SQ_W_DEF = sq_w(ROOT_W_DEF);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_SQ   = 3'd1,
      S_CB   = 3'd2,
      S_CMP  = 3'd3,
      S_DONE = 3'd4
   } state_t;

endpackage

// File: rtl/cube_root_mul.sv
// Unsigned A_W x B_W combinational multiplier, summed as shifted partial products.
module cube_root_mul #(
   parameter int A_W = 16,
   parameter int B_W = 8
) (
   input  logic [A_W-1:0]     a,
   input  logic [B_W-1:0]     b,
   output logic [A_W+B_W-1:0] p
);

   always_comb begin
      p = '0;
      for (int j = 0; j < B_W; j++) begin
         if (b[j]) p = p + ((A_W+B_W)'(a) << j);
      end
   end

endmodule

// File: rtl/cube_root_seq.sv
// Sequential floor cube root, one root bit per SQ/CB/CMP pass over a shared multiplier.
// Optional remainder/exact outputs are enabled by defining CUBE_ROOT_REM_EN.
module cube_root_seq
   import cube_arith_pkg::*;
#(
   parameter int ROOT_W = ROOT_W_DEF
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [in_w(ROOT_W)-1:0]   x_i,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [ROOT_W-1:0]         root_o
`ifdef CUBE_ROOT_REM_EN
   ,
   output logic [in_w(ROOT_W)-1:0]   rem_o,
   output logic                      exact_o
`endif
);

   localparam int IN_W = in_w(ROOT_W);
   localparam int SQ_W = sq_w(ROOT_W);
   localparam int BI_W = (ROOT_W > 1) ? $clog2(ROOT_W) : 1;

   state_t            state;
   logic [IN_W-1:0]   x_q;
   logic [ROOT_W-1:0] root;
   logic [BI_W-1:0]   bit_idx;
   logic [ROOT_W-1:0] trial;
   logic [SQ_W-1:0]   sq;
   logic [IN_W-1:0]   cb;
   logic [SQ_W-1:0]   mul_a;
   logic [IN_W-1:0]   prod;
   logic              keep;

   assign in_ready = (state == S_IDLE);
   assign root_o   = root;
   assign trial    = root | (ROOT_W'(1) << bit_idx);
   assign keep     = (cb <= x_q);

   // Operand A: zero-extended trial while squaring, the stored square while cubing.
   assign mul_a = (state == S_CB) ? sq : SQ_W'(trial);

   cube_root_mul #(
      .A_W (SQ_W),
      .B_W (ROOT_W)
   ) u_mul (
      .a (mul_a),
      .b (trial),
      .p (prod)
   );

`ifdef CUBE_ROOT_REM_EN
   logic [IN_W-1:0] cube_acc;
   logic [IN_W-1:0] acc_next;
   logic [IN_W-1:0] rem_next;
   logic [IN_W-1:0] rem_q;
   logic            exact_q;

   assign acc_next = keep ? cb : cube_acc;
   assign rem_next = x_q - acc_next;
   assign rem_o    = rem_q;
   assign exact_o  = exact_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         x_q       <= '0;
         root      <= '0;
         bit_idx   <= '0;
         sq        <= '0;
         cb        <= '0;
         out_valid <= 1'b0;
`ifdef CUBE_ROOT_REM_EN
         cube_acc  <= '0;
         rem_q     <= '0;
         exact_q   <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  x_q     <= x_i;
                  root    <= '0;
                  bit_idx <= BI_W'(ROOT_W - 1);
`ifdef CUBE_ROOT_REM_EN
                  cube_acc <= '0;
`endif
                  state   <= S_SQ;
               end
            end
            S_SQ: begin
               sq    <= prod[SQ_W-1:0];
               state <= S_CB;
            end
            S_CB: begin
               cb    <= prod;
               state <= S_CMP;
            end
            S_CMP: begin
               if (keep) root <= trial;
`ifdef CUBE_ROOT_REM_EN
               cube_acc <= acc_next;
`endif
               if (bit_idx == '0) begin
                  out_valid <= 1'b1;
`ifdef CUBE_ROOT_REM_EN
                  rem_q     <= rem_next;
                  exact_q   <= (rem_next == '0);
`endif
                  state     <= S_DONE;
               end else begin
                  bit_idx <= bit_idx - 1'b1;
                  state   <= S_SQ;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
